keyboard_scanner: RTL and testbench
===================================

Name: keyboard_scanner

Overview:
- Reads the Model 100 key matrix over the 8 data pins it shares with the LCD; it is the reader that time-shares the bus with the LCD writer.
- Periodically pauses LCD refresh, takes the bus, and drives each column low in turn.
- Samples the pulled-up row lines and debounces each key.
- Emits make/break scancodes over a valid/ready handshake toward the UART transmitter.

Parameters:
- NUM_COLS, 9, number of key columns scanned (max 16).
- SCAN_INTERVAL, 48000, clk cycles from end of one scan to start of the next (1 ms at 48 MHz).
- TURNAROUND, 16, clk cycles between releasing bus output-enable and driving the first column.
- SETTLE, 500, clk cycles a column is held low before rows are sampled.
- DEBOUNCE_SCANS, 3, consecutive differing scans required to change a key's stable state (1..15).

Ports:
- clk  in  1  48 MHz system clock.
- reset  in  1  asynchronous, active-high.
- lcd_pause  out  1  high requests the LCD controller stop after its current transfer; feeds the LCD frame strobe inverted.
- lcd_idle  in  1  high when the LCD controller is not driving the bus.
- bus_output_enable  out  1  OE for the shared data-pin SB_IO buffers (1 = LCD drives, 0 = pins are inputs).
- col_select  out  1  high steers col_drive onto the shared column/chip-select pins instead of LCD chip selects.
- col_drive  out  NUM_COLS  active-low column drive; all ones when idle.
- row_in  in  8  raw row pins, active-low, pulled up.
- event_valid  out  1  scancode available.
- event_ready  in  1  consumer accepts the scancode when valid && ready at a clk edge.
- event_code  out  8  bit7 = 1 make / 0 break; bits6:3 = column; bits2:0 = row.

Behaviour:
- Reset values: lcd_pause=0, bus_output_enable=1, col_select=0, col_drive=all ones, event_valid=0, event_code=0.
- Reset also clears all stable key states (released) and all debounce counters, and puts the FSM in IDLE. Asserting reset mid-scan releases the bus the same way.
- IDLE: the interval counter counts to SCAN_INTERVAL-1, then the FSM moves to PAUSE and lcd_pause=1. The counter restarts on every entry to IDLE.
- PAUSE: wait for lcd_idle=1 with no timeout. If lcd_idle is already high, the FSM leaves PAUSE on the next cycle. On exit, bus_output_enable=0 and col_select=1.
- TURN: wait TURNAROUND cycles, then set column index c=0.
- DRIVE: col_drive = ~(1<<c). Hold for SETTLE cycles.
- SAMPLE: in one cycle, raw[c] <= ~row_in and col_drive returns to all ones. If c==NUM_COLS-1 go to RESTORE, else c++ and return to DRIVE.
- RESTORE (one cycle): col_select=0, bus_output_enable=1, lcd_pause=0. Key index k=0.
- WALK: one key per cycle, k = 0..NUM_COLS*8-1, with col=k[6:3] and row=k[2:0].
  - If raw==stable, counter <= 0.
  - Otherwise counter++. When counter+1 == DEBOUNCE_SCANS: stable <= raw, counter <= 0, event_code <= {raw, col, row}, event_valid=1.
  - While event_valid && !event_ready the walk stalls on the same key.
  - event_valid drops in the cycle after acceptance; event_code is held stable while valid.
- After the last key the FSM returns to IDLE. The next scan does not start before the walk completes, so under back-pressure the scan period stretches.
- Event ordering: increasing k within a scan; one event per key per scan at most.
- The LCD bus is held only from PAUSE exit to RESTORE, which is about TURNAROUND + NUM_COLS*(SETTLE+1) + 1 cycles.

Decomposition:
- Package keyboard_pkg holds:
  - FSM state encoding (IDLE, PAUSE, TURN, DRIVE, SAMPLE, RESTORE, WALK);
  - event_code field positions (MAKE_BIT=7, COL_MSB=6, COL_LSB=3, ROW_MSB=2, ROW_LSB=0);
  - MAX_COLS=16.
- One sub-module, keyboard_debounce, owns the stable/counter arrays and the per-key update rule. It takes raw bit, k and an enable, and returns change + new state. The scanner owns the FSM, bus arbitration and the event handshake.

Test Plan (SCAN_INTERVAL=100, TURNAROUND=2, SETTLE=4, DEBOUNCE_SCANS=3, NUM_COLS=9, event_ready=1 unless stated):
- Reset with no keys pressed -> after 5 scans no event_valid. Each scan: lcd_pause rises; bus_output_enable falls only after lcd_idle=1; col_drive shows 1FE,1FD,…,0FF each for 5 cycles.
- Hold row 3 low while col 5 is driven, for 3 scans -> exactly one event_code=0xAB (make, col 5, row 3), at the end of the 3rd scan. Release for 3 scans -> one event_code=0x2B.
- Key glitches pressed for 2 scans then released -> no event; counter reset confirmed by needing 3 more pressed scans to get 0xAB.
- Hold lcd_idle=0 for 1000 cycles after lcd_pause -> bus_output_enable stays 1, col_drive stays 1FF, no sampling; scan proceeds once lcd_idle=1.
- Two keys (c0 r0, c8 r7) press together with event_ready=0 for 50 cycles -> 0x80 held stable on event_code until ready, then 0xC7. No new lcd_pause until the walk finishes.
- Assert reset during DRIVE of col 4 -> same cycle: bus_output_enable=1, col_select=0, col_drive=1FF, lcd_pause=0, event_valid=0. A previously stable pressed key re-reports make after 3 scans.

Source files
------------

// File: rtl/keyboard_pkg.sv
// Shared definitions for the Model 100 key-matrix scanner: FSM states and
// scancode field layout.
package keyboard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSE,
        ST_TURN,
        ST_DRIVE,
        ST_SAMPLE,
        ST_RESTORE,
        ST_WALK
    } state_e;

    localparam int MAKE_BIT = 7;
    localparam int COL_MSB  = 6;
    localparam int COL_LSB  = 3;
    localparam int ROW_MSB  = 2;
    localparam int ROW_LSB  = 0;

    localparam int MAX_COLS = 16;
    localparam int KEY_W    = 7;   // enough to index MAX_COLS * 8 keys
    localparam int DB_CNT_W = 4;   // holds DEBOUNCE_SCANS up to 15

endpackage

// File: rtl/keyboard_debounce.sv
// Per-key debounce state: one stable bit and one scan counter per key,
// updated for the single key selected by k when en is high.
module keyboard_debounce
    import keyboard_pkg::*;
#(
    parameter int NUM_KEYS       = 72,
    parameter int DEBOUNCE_SCANS = 3,
    localparam int KW            = $clog2(NUM_KEYS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [KW-1:0] k,
    input  logic          raw,
    output logic          change,
    output logic          new_state
);

    localparam logic [DB_CNT_W-1:0] LIMIT = DB_CNT_W'(DEBOUNCE_SCANS);

    logic [NUM_KEYS-1:0]                stable_q, stable_d;
    logic [NUM_KEYS-1:0][DB_CNT_W-1:0]  cnt_q, cnt_d;
    logic [DB_CNT_W-1:0]                cnt_inc;

    always_comb begin
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        change    = 1'b0;
        new_state = raw;
        cnt_inc   = cnt_q[k] + DB_CNT_W'(1);
        if (en) begin
            if (raw == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_inc == LIMIT) begin
                stable_d[k] = raw;
                cnt_d[k]    = '0;
                change      = 1'b1;
            end else begin
                cnt_d[k] = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/keyboard_scanner.sv
// Key-matrix scanner sharing the LCD data pins: borrows the bus, strobes each
// column, then walks every key through the debouncer and emits scancodes.
module keyboard_scanner
    import keyboard_pkg::*;
#(
    parameter int NUM_COLS       = 9,
    parameter int SCAN_INTERVAL  = 48000,
    parameter int TURNAROUND     = 16,
    parameter int SETTLE         = 500,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                clk,
    input  logic                reset,
    output logic                lcd_pause,
    input  logic                lcd_idle,
    output logic                bus_output_enable,
    output logic                col_select,
    output logic [NUM_COLS-1:0] col_drive,
    input  logic [7:0]          row_in,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [7:0]          event_code
);

    localparam int NUM_KEYS = NUM_COLS * 8;
    localparam int KW       = $clog2(NUM_KEYS);
    localparam int TMR_MAX1 = (SCAN_INTERVAL > SETTLE) ? SCAN_INTERVAL : SETTLE;
    localparam int TMR_MAX  = (TMR_MAX1 > TURNAROUND) ? TMR_MAX1 : TURNAROUND;
    localparam int TW       = $clog2(TMR_MAX + 1);

    localparam logic [TW-1:0]    IDLE_LAST   = TW'(SCAN_INTERVAL - 1);
    localparam logic [TW-1:0]    TURN_LAST   = TW'(TURNAROUND - 1);
    localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [3:0]       COL_LAST    = 4'(NUM_COLS - 1);
    localparam logic [KEY_W-1:0] KEY_LAST    = KEY_W'(NUM_KEYS - 1);

    state_e              state_q, state_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [3:0]          col_q, col_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [NUM_KEYS-1:0] raw_q, raw_d;
    logic                event_valid_q, event_valid_d;
    logic [7:0]          event_code_q, event_code_d;
    logic                walk_en;
    logic                key_change;
    logic                key_state;

    // The walk only advances when no scancode is stuck waiting for the consumer.
    assign walk_en = (state_q == ST_WALK) && (!event_valid_q || event_ready);

    keyboard_debounce #(
        .NUM_KEYS       (NUM_KEYS),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .en        (walk_en),
        .k         (key_q[KW-1:0]),
        .raw       (raw_q[key_q[KW-1:0]]),
        .change    (key_change),
        .new_state (key_state)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + TW'(1);
        col_d   = col_q;
        key_d   = key_q;
        case (state_q)
            ST_IDLE: begin
                if (tmr_q == IDLE_LAST) begin
                    state_d = ST_PAUSE;
                    tmr_d   = '0;
                end
            end
            ST_PAUSE: begin
                tmr_d = '0;
                if (lcd_idle) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                if (tmr_q == TURN_LAST) begin
                    state_d = ST_DRIVE;
                    tmr_d   = '0;
                    col_d   = '0;
                end
            end
            ST_DRIVE: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    tmr_d   = '0;
                end
            end
            ST_SAMPLE: begin
                tmr_d = '0;
                if (col_q == COL_LAST) begin
                    state_d = ST_RESTORE;
                end else begin
                    col_d   = col_q + 4'd1;
                    state_d = ST_DRIVE;
                end
            end
            ST_RESTORE: begin
                tmr_d   = '0;
                key_d   = '0;
                state_d = ST_WALK;
            end
            ST_WALK: begin
                tmr_d = '0;
                if (walk_en) begin
                    if (key_q == KEY_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        key_d = key_q + KEY_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    always_comb begin
        raw_d = raw_q;
        if (state_q == ST_SAMPLE) begin
            raw_d[{col_q, 3'b000} +: 8] = ~row_in;
        end
        event_valid_d = event_valid_q;
        event_code_d  = event_code_q;
        if (event_valid_q && event_ready) begin
            event_valid_d = 1'b0;
        end
        if (key_change) begin
            event_valid_d                   = 1'b1;
            event_code_d[MAKE_BIT]          = key_state;
            event_code_d[COL_MSB:COL_LSB]   = key_q[6:3];
            event_code_d[ROW_MSB:ROW_LSB]   = key_q[2:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q         <= '0;
            col_q         <= '0;
            key_q         <= '0;
            event_valid_q <= 1'b0;
            event_code_q  <= '0;
        end else begin
            tmr_q         <= tmr_d;
            col_q         <= col_d;
            key_q         <= key_d;
            event_valid_q <= event_valid_d;
            event_code_q  <= event_code_d;
        end
    end

    // Row samples are only read after a full column sweep, so they need no reset.
    always_ff @(posedge clk) begin
        raw_q <= raw_d;
    end

    always_comb begin
        lcd_pause         = 1'b0;
        bus_output_enable = 1'b1;
        col_select        = 1'b0;
        col_drive         = '1;
        case (state_q)
            ST_PAUSE: begin
                lcd_pause = 1'b1;
            end
            ST_TURN: begin
                lcd_pause         = 1'b1;
                bus_output_enable = 1'b0;
                col_select        = 1'b1;
            end
            ST_DRIVE, ST_SAMPLE: begin
                lcd_pause         = 1'b1;
                bus_output_enable = 1'b0;
                col_select        = 1'b1;
                col_drive         = ~(NUM_COLS'(1) << col_q);
            end
            default: begin
            end
        endcase
    end

    assign event_valid = event_valid_q;
    assign event_code  = event_code_q;

endmodule

// File: tb/tb_keyboard_scanner.sv
// Directed bench for keyboard_scanner with a small key-matrix model driving row_in.
module tb_keyboard_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_pause;
    logic       lcd_idle;
    logic       bus_output_enable;
    logic       col_select;
    logic [8:0] col_drive;
    logic [7:0] row_in;
    logic       event_valid;
    logic       event_ready;
    logic [7:0] event_code;

    logic [71:0] pressed;
    logic [7:0]  ev_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct {
        int         key;
        logic       down;
        int         exp_n;
        logic [7:0] exp_code;
    } vec_t;

    vec_t vecs[20];

    always #5 clk = ~clk;

    keyboard_scanner #(
        .NUM_COLS       (9),
        .SCAN_INTERVAL  (100),
        .TURNAROUND     (2),
        .SETTLE         (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .lcd_pause         (lcd_pause),
        .lcd_idle          (lcd_idle),
        .bus_output_enable (bus_output_enable),
        .col_select        (col_select),
        .col_drive         (col_drive),
        .row_in            (row_in),
        .event_valid       (event_valid),
        .event_ready       (event_ready),
        .event_code        (event_code)
    );

    // Pressed switch shorts its row to a column that is currently driven low.
    always_comb begin
        row_in = 8'hFF;
        for (int c = 0; c < 9; c++) begin
            for (int r = 0; r < 8; r++) begin
                if (!col_drive[c] && pressed[c*8+r]) row_in[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && event_valid && event_ready) ev_q.push_back(event_code);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_restore(input string name);
        int n;
        n = 0;
        while (!lcd_pause && n < 600) begin @(negedge clk); n++; end
        check({name, "_pause"}, 32'(lcd_pause), 1);
        n = 0;
        while (bus_output_enable && n < 1200) begin @(negedge clk); n++; end
        n = 0;
        while (!bus_output_enable && n < 200) begin @(negedge clk); n++; end
        check({name, "_restore"}, 32'(bus_output_enable), 1);
    endtask

    task automatic run_scan(input string name, input int exp_n,
                            input logic [7:0] c0, input logic [7:0] c1);
        int base;
        base = ev_q.size();
        wait_restore(name);
        repeat (80) @(negedge clk);
        check({name, "_count"}, 32'(ev_q.size() - base), 32'(exp_n));
        if (exp_n > 0 && ev_q.size() > base) check({name, "_code0"}, 32'(ev_q[base]), 32'(c0));
        if (exp_n > 1 && ev_q.size() > base + 1) check({name, "_code1"}, 32'(ev_q[base+1]), 32'(c1));
    endtask

    initial begin
        int n;
        int bad;
        int base;
        logic [8:0] exp_cd;

        for (int i = 0; i < 5; i++) vecs[i] = '{0, 1'b0, 0, 8'h00};
        vecs[5]  = '{43, 1'b1, 0, 8'h00};
        vecs[6]  = '{43, 1'b1, 0, 8'h00};
        vecs[7]  = '{43, 1'b1, 1, 8'hAB};
        vecs[8]  = '{43, 1'b0, 0, 8'h00};
        vecs[9]  = '{43, 1'b0, 0, 8'h00};
        vecs[10] = '{43, 1'b0, 1, 8'h2B};
        vecs[11] = '{43, 1'b1, 0, 8'h00};
        vecs[12] = '{43, 1'b1, 0, 8'h00};
        vecs[13] = '{43, 1'b0, 0, 8'h00};
        vecs[14] = '{43, 1'b1, 0, 8'h00};
        vecs[15] = '{43, 1'b1, 0, 8'h00};
        vecs[16] = '{43, 1'b1, 1, 8'hAB};
        vecs[17] = '{43, 1'b0, 0, 8'h00};
        vecs[18] = '{43, 1'b0, 0, 8'h00};
        vecs[19] = '{43, 1'b0, 1, 8'h2B};

        reset       = 1'b0;
        lcd_idle    = 1'b1;
        event_ready = 1'b1;
        pressed     = '0;
        #2 reset = 1'b1;
        #1;
        check("rst_pause", 32'(lcd_pause), 0);
        check("rst_oe", 32'(bus_output_enable), 1);
        check("rst_colsel", 32'(col_select), 0);
        check("rst_coldrive", 32'(col_drive), 32'h1FF);
        check("rst_valid", 32'(event_valid), 0);
        check("rst_code", 32'(event_code), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Bus sequencing and column strobe shape of one scan.
        n = 0;
        while (!lcd_pause && n < 600) begin @(negedge clk); n++; end
        check("shape_pause", 32'(lcd_pause), 1);
        check("shape_oe_before_idle", 32'(bus_output_enable), 1);
        @(negedge clk);
        check("shape_oe_fall", 32'(bus_output_enable), 0);
        check("shape_colsel", 32'(col_select), 1);
        n = 0;
        while (col_drive == 9'h1FF && n < 20) begin @(negedge clk); n++; end
        check("shape_turn_len", 32'(n), 2);
        for (int c = 0; c < 9; c++) begin
            exp_cd = ~(9'd1 << c);
            check($sformatf("shape_col%0d_val", c), 32'(col_drive), 32'(exp_cd));
            n = 0;
            while (col_drive == exp_cd && n < 20) begin @(negedge clk); n++; end
            check($sformatf("shape_col%0d_len", c), 32'(n), 5);
        end
        check("shape_restore_cd", 32'(col_drive), 32'h1FF);
        check("shape_restore_oe", 32'(bus_output_enable), 1);
        check("shape_restore_colsel", 32'(col_select), 0);
        check("shape_restore_pause", 32'(lcd_pause), 0);
        repeat (80) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            pressed[vecs[i].key] = vecs[i].down;
            run_scan($sformatf("vec%0d", i), vecs[i].exp_n, vecs[i].exp_code, 8'h00);
        end

        // LCD stays busy: bus must not be taken.
        lcd_idle = 1'b0;
        n = 0;
        while (!lcd_pause && n < 600) begin @(negedge clk); n++; end
        check("busy_pause", 32'(lcd_pause), 1);
        bad = 0;
        repeat (1000) begin
            if (bus_output_enable !== 1'b1 || col_drive !== 9'h1FF ||
                col_select !== 1'b0 || lcd_pause !== 1'b1) bad++;
            @(negedge clk);
        end
        check("busy_hold", 32'(bad), 0);
        lcd_idle = 1'b1;
        @(negedge clk);
        check("busy_oe_fall", 32'(bus_output_enable), 0);
        n = 0;
        while (!bus_output_enable && n < 200) begin @(negedge clk); n++; end
        check("busy_restore", 32'(bus_output_enable), 1);
        repeat (80) @(negedge clk);

        // Two simultaneous makes under consumer back-pressure.
        event_ready = 1'b0;
        pressed[0]  = 1'b1;
        pressed[71] = 1'b1;
        run_scan("bp_s1", 0, 8'h00, 8'h00);
        run_scan("bp_s2", 0, 8'h00, 8'h00);
        base = ev_q.size();
        wait_restore("bp_s3");
        n = 0;
        while (!event_valid && n < 20) begin @(negedge clk); n++; end
        check("bp_valid", 32'(event_valid), 1);
        bad = 0;
        repeat (50) begin
            if (event_valid !== 1'b1 || event_code !== 8'h80 || lcd_pause !== 1'b0) bad++;
            @(negedge clk);
        end
        check("bp_hold", 32'(bad), 0);
        check("bp_code_held", 32'(event_code), 32'h80);
        event_ready = 1'b1;
        repeat (90) @(negedge clk);
        check("bp_count", 32'(ev_q.size() - base), 2);
        if (ev_q.size() > base) check("bp_first", 32'(ev_q[base]), 32'h80);
        if (ev_q.size() > base + 1) check("bp_second", 32'(ev_q[base+1]), 32'hC7);
        check("bp_valid_drop", 32'(event_valid), 0);

        pressed[0]  = 1'b0;
        pressed[71] = 1'b0;
        run_scan("bprel_s1", 0, 8'h00, 8'h00);
        run_scan("bprel_s2", 0, 8'h00, 8'h00);
        run_scan("bprel_s3", 2, 8'h00, 8'h47);

        // Reset in the middle of a column strobe.
        pressed[43] = 1'b1;
        run_scan("pre_s1", 0, 8'h00, 8'h00);
        run_scan("pre_s2", 0, 8'h00, 8'h00);
        run_scan("pre_s3", 1, 8'hAB, 8'h00);
        n = 0;
        while (col_drive !== 9'h1EF && n < 500) begin @(negedge clk); n++; end
        check("mid_col4", 32'(col_drive), 32'h1EF);
        reset = 1'b1;
        #1;
        check("mid_oe", 32'(bus_output_enable), 1);
        check("mid_colsel", 32'(col_select), 0);
        check("mid_coldrive", 32'(col_drive), 32'h1FF);
        check("mid_pause", 32'(lcd_pause), 0);
        check("mid_valid", 32'(event_valid), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        run_scan("post_s1", 0, 8'h00, 8'h00);
        run_scan("post_s2", 0, 8'h00, 8'h00);
        run_scan("post_s3", 1, 8'hAB, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
